datapath_seq: RTL and testbench

Parametrised successor to the bus-based register/ALU datapath. It holds NREGS general registers plus the A and G staging registers, and replaces the tri-state bus with an internal mux-driven bus. It sequences its own multi-cycle transfers from a single instruction accepted over a valid/ready handshake, so no one-hot enables come from outside. It also adds a flags register and a debug read port, and sits directly under the processor control unit.

---
 rtl/datapath_pkg.sv | 27 ++
 rtl/datapath_seq_alu_gen.sv | 44 ++++
 rtl/datapath_seq.sv | 148 ++++++++++++++
 tb/tb_datapath_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared types for the sequenced register/ALU datapath: opcodes, FSM states
// and the bit positions inside the {C,N,Z} flags word.
package datapath_pkg;

    typedef enum logic [2:0] {
        OP_MV  = 3'b000,
        OP_MVI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_CMP = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

endpackage

// File: rtl/datapath_seq_alu_gen.sv
// Combinational WIDTH-bit ALU producing a result and the {C,N,Z} flags.
module alu_gen
    import datapath_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  op_t              op,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);

    logic [WIDTH:0] ext;
    logic           carry;

    always_comb begin
        ext    = '0;
        carry  = 1'b0;
        result = operand_b;
        case (op)
            OP_ADD: begin
                ext    = {1'b0, operand_a} + {1'b0, operand_b};
                result = ext[WIDTH-1:0];
                carry  = ext[WIDTH];
            end
            // C is the inverted borrow, i.e. set when A >= B unsigned
            OP_SUB, OP_CMP: begin
                ext    = {1'b0, operand_a} - {1'b0, operand_b};
                result = ext[WIDTH-1:0];
                carry  = ~ext[WIDTH];
            end
            OP_AND:  result = operand_a & operand_b;
            OP_OR:   result = operand_a | operand_b;
            OP_XOR:  result = operand_a ^ operand_b;
            default: result = operand_b;
        endcase
        flags         = '0;
        flags[FLAG_C] = carry;
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_Z] = (result == '0);
    end

endmodule

// File: rtl/datapath_seq.sv
// Register file, A/G staging registers and an internal mux bus, sequenced by
// a four-state FSM from one instruction accepted over valid/ready.
module datapath_seq
    import datapath_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [RW-1:0]    in_rx,
    input  logic [RW-1:0]    in_ry,
    input  logic [WIDTH-1:0] in_imm,
    output logic             done,
    output logic [2:0]       flags,
    output logic [WIDTH-1:0] bus,
    input  logic [RW-1:0]    dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    state_t           state_q, state_d;
    op_t              ir_op_q;
    logic [RW-1:0]    ir_rx_q, ir_ry_q;
    logic [WIDTH-1:0] ir_imm_q;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] a_q, g_q;
    logic [2:0]       flags_q;

    logic [WIDTH-1:0] rx_val, ry_val;
    logic             wr_en, a_en, g_en, accept;
    logic [WIDTH-1:0] alu_result;
    logic [2:0]       alu_flags;

    // Out-of-range indices match no entry, so reads yield 0
    always_comb begin
        rx_val   = '0;
        ry_val   = '0;
        dbg_data = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (ir_rx_q == RW'(i)) rx_val   = regs_q[i];
            if (ir_ry_q == RW'(i)) ry_val   = regs_q[i];
            if (dbg_sel == RW'(i)) dbg_data = regs_q[i];
        end
    end

    alu_gen #(.WIDTH(WIDTH)) u_alu (
        .operand_a (a_q),
        .operand_b (bus),
        .op        (ir_op_q),
        .result    (alu_result),
        .flags     (alu_flags)
    );

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        done     = 1'b0;
        bus      = '0;
        wr_en    = 1'b0;
        a_en     = 1'b0;
        g_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = S_T1;
                end
            end
            S_T1: begin
                case (ir_op_q)
                    OP_MV: begin
                        bus     = ry_val;
                        wr_en   = 1'b1;
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                    OP_MVI: begin
                        bus     = ir_imm_q;
                        wr_en   = 1'b1;
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                    default: begin
                        bus     = rx_val;
                        a_en    = 1'b1;
                        state_d = S_T2;
                    end
                endcase
            end
            S_T2: begin
                bus  = ry_val;
                g_en = 1'b1;
                if (ir_op_q == OP_CMP) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_T3;
                end
            end
            S_T3: begin
                bus     = g_q;
                wr_en   = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ir_op_q  <= OP_MV;
            ir_rx_q  <= '0;
            ir_ry_q  <= '0;
            ir_imm_q <= '0;
            a_q      <= '0;
            g_q      <= '0;
            flags_q  <= '0;
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ir_op_q  <= op_t'(in_op);
                ir_rx_q  <= in_rx;
                ir_ry_q  <= in_ry;
                ir_imm_q <= in_imm;
            end
            if (a_en) a_q <= bus;
            if (g_en) begin
                g_q     <= alu_result;
                flags_q <= alu_flags;
            end
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (wr_en && ir_rx_q == RW'(i)) regs_q[i] <= bus;
            end
        end
    end

    assign flags = flags_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq: default build plus an NREGS=6 build for
// out-of-range register indices.
module tb_datapath_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, v6;
    logic [2:0]  in_op, in_rx, in_ry, dbg_sel;
    logic [15:0] in_imm;

    logic        in_ready, done, rdy6, done6;
    logic [2:0]  flags, flags6;
    logic [15:0] bus, bus6, dbg_data, dbg6;

    int passed = 0;
    int total  = 0;
    logic [15:0] bus_log [9];

    always #5 clk = ~clk;

    datapath_seq #(.WIDTH(16), .NREGS(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rx(in_rx), .in_ry(in_ry), .in_imm(in_imm),
        .done(done), .flags(flags), .bus(bus), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    datapath_seq #(.WIDTH(16), .NREGS(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(rdy6),
        .in_op(in_op), .in_rx(in_rx), .in_ry(in_ry), .in_imm(in_imm),
        .done(done6), .flags(flags6), .bus(bus6), .dbg_sel(dbg_sel), .dbg_data(dbg6)
    );

    // Called and returns on a falling edge; returns on the done cycle (lat=0 on timeout)
    task automatic run(input logic six, input logic [2:0] op, input logic [2:0] rx,
                       input logic [2:0] ry, input logic [15:0] imm, output int lat);
        int w = 0;
        while (!(six ? rdy6 : in_ready) && w < 20) begin
            @(negedge clk);
            w++;
        end
        in_op = op; in_rx = rx; in_ry = ry; in_imm = imm;
        if (six) v6 = 1'b1; else in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        v6       = 1'b0;
        lat      = 0;
        for (int k = 1; k <= 8; k++) begin
            bus_log[k] = six ? bus6 : bus;
            if (six ? done6 : done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; v6 = 1'b0;
        in_op = 3'd0; in_rx = 3'd0; in_ry = 3'd0; in_imm = 16'd0; dbg_sel = 3'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", in_ready); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else passed++;
        total++; if (flags !== 3'b000) $display("FAIL reset_flags got %b exp 000", flags); else passed++;
        total++; if (bus !== 16'h0000) $display("FAIL reset_bus got %h exp 0000", bus); else passed++;
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i);
            #1;
            if (dbg_data !== 16'h0000) bad++;
        end
        total++; if (bad != 0) $display("FAIL reset_regs got %0d nonzero exp 0", bad); else passed++;
    endtask

    task automatic test_mvi;
        int lat;
        @(negedge clk);
        run(1'b0, 3'b001, 3'd3, 3'd0, 16'h1234, lat);
        total++; if (lat !== 1) $display("FAIL mvi_latency got %0d exp 1", lat); else passed++;
        total++; if (bus_log[1] !== 16'h1234) $display("FAIL mvi_bus got %h exp 1234", bus_log[1]); else passed++;
        @(negedge clk);
        dbg_sel = 3'd3; #1;
        total++; if (dbg_data !== 16'h1234) $display("FAIL mvi_r3 got %h exp 1234", dbg_data); else passed++;
        total++; if (flags !== 3'b000) $display("FAIL mvi_flags got %b exp 000", flags); else passed++;
    endtask

    task automatic test_add;
        int lat;
        run(1'b0, 3'b001, 3'd1, 3'd0, 16'hFFFF, lat);
        @(negedge clk);
        run(1'b0, 3'b001, 3'd2, 3'd0, 16'h0001, lat);
        @(negedge clk);
        run(1'b0, 3'b010, 3'd1, 3'd2, 16'h0000, lat);
        total++; if (lat !== 3) $display("FAIL add_latency got %0d exp 3", lat); else passed++;
        total++; if ({bus_log[1], bus_log[2], bus_log[3]} !== {16'hFFFF, 16'h0001, 16'h0000})
            $display("FAIL add_bus_seq got %h %h %h exp ffff 0001 0000", bus_log[1], bus_log[2], bus_log[3]);
        else passed++;
        @(negedge clk);
        dbg_sel = 3'd1; #1;
        total++; if (dbg_data !== 16'h0000) $display("FAIL add_r1 got %h exp 0000", dbg_data); else passed++;
        total++; if (flags !== 3'b101) $display("FAIL add_flags got %b exp 101", flags); else passed++;
    endtask

    task automatic test_cmp_sub;
        int lat;
        run(1'b0, 3'b001, 3'd4, 3'd0, 16'd5, lat);
        @(negedge clk);
        run(1'b0, 3'b001, 3'd5, 3'd0, 16'd7, lat);
        @(negedge clk);
        run(1'b0, 3'b111, 3'd4, 3'd5, 16'd0, lat);
        total++; if (lat !== 2) $display("FAIL cmp_latency got %0d exp 2", lat); else passed++;
        @(negedge clk);
        dbg_sel = 3'd4; #1;
        total++; if (dbg_data !== 16'd5) $display("FAIL cmp_r4 got %h exp 0005", dbg_data); else passed++;
        total++; if (flags !== 3'b010) $display("FAIL cmp_flags got %b exp 010", flags); else passed++;
        run(1'b0, 3'b011, 3'd5, 3'd4, 16'd0, lat);
        total++; if (lat !== 3) $display("FAIL sub_latency got %0d exp 3", lat); else passed++;
        @(negedge clk);
        dbg_sel = 3'd5; #1;
        total++; if (dbg_data !== 16'd2) $display("FAIL sub_r5 got %h exp 0002", dbg_data); else passed++;
        total++; if (flags !== 3'b100) $display("FAIL sub_flags got %b exp 100", flags); else passed++;
    endtask

    task automatic test_logic_ops;
        int lat;
        run(1'b0, 3'b001, 3'd1, 3'd0, 16'hF0F0, lat); @(negedge clk);
        run(1'b0, 3'b001, 3'd2, 3'd0, 16'hFF00, lat); @(negedge clk);
        run(1'b0, 3'b100, 3'd1, 3'd2, 16'h0000, lat); @(negedge clk);
        dbg_sel = 3'd1; #1;
        total++; if (dbg_data !== 16'hF000) $display("FAIL and_r1 got %h exp f000", dbg_data); else passed++;
        total++; if (flags !== 3'b010) $display("FAIL and_flags got %b exp 010", flags); else passed++;
        run(1'b0, 3'b110, 3'd2, 3'd2, 16'h0000, lat); @(negedge clk);
        dbg_sel = 3'd2; #1;
        total++; if (dbg_data !== 16'h0000) $display("FAIL xor_self got %h exp 0000", dbg_data); else passed++;
        total++; if (flags !== 3'b001) $display("FAIL xor_flags got %b exp 001", flags); else passed++;
        run(1'b0, 3'b001, 3'd3, 3'd0, 16'h4000, lat); @(negedge clk);
        run(1'b0, 3'b010, 3'd3, 3'd3, 16'h0000, lat); @(negedge clk);
        dbg_sel = 3'd3; #1;
        total++; if (dbg_data !== 16'h8000) $display("FAIL add_self got %h exp 8000", dbg_data); else passed++;
        total++; if (flags !== 3'b010) $display("FAIL add_self_flags got %b exp 010", flags); else passed++;
        run(1'b0, 3'b000, 3'd0, 3'd3, 16'h0000, lat); @(negedge clk);
        dbg_sel = 3'd0; #1;
        total++; if (dbg_data !== 16'h8000) $display("FAIL mv_r0 got %h exp 8000", dbg_data); else passed++;
        total++; if (flags !== 3'b010) $display("FAIL mv_keeps_flags got %b exp 010", flags); else passed++;
        run(1'b0, 3'b001, 3'd6, 3'd0, 16'h0001, lat); @(negedge clk);
        run(1'b0, 3'b101, 3'd6, 3'd2, 16'h0000, lat); @(negedge clk);
        dbg_sel = 3'd6; #1;
        total++; if (dbg_data !== 16'h0001) $display("FAIL or_r6 got %h exp 0001", dbg_data); else passed++;
        total++; if (flags !== 3'b000) $display("FAIL or_flags got %b exp 000", flags); else passed++;
    endtask

    task automatic test_back_to_back;
        int lat;
        int idx = 0;
        logic acc;
        logic [7:0] rdy_seen, done_seen;
        logic [2:0]  t_op  [3];
        logic [2:0]  t_rx  [3];
        logic [2:0]  t_ry  [3];
        logic [15:0] t_imm [3];
        t_op[0] = 3'b000; t_rx[0] = 3'd6; t_ry[0] = 3'd3; t_imm[0] = 16'h0000;
        t_op[1] = 3'b000; t_rx[1] = 3'd5; t_ry[1] = 3'd6; t_imm[1] = 16'h0000;
        t_op[2] = 3'b001; t_rx[2] = 3'd3; t_ry[2] = 3'd0; t_imm[2] = 16'h0022;
        run(1'b0, 3'b001, 3'd3, 3'd0, 16'h0011, lat);
        @(negedge clk);
        in_op = t_op[0]; in_rx = t_rx[0]; in_ry = t_ry[0]; in_imm = t_imm[0];
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            rdy_seen[c]  = in_ready;
            done_seen[c] = done;
            acc = in_ready && in_valid;
            @(posedge clk);
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    in_op = t_op[idx]; in_rx = t_rx[idx]; in_ry = t_ry[idx]; in_imm = t_imm[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        total++; if (idx !== 3) $display("FAIL b2b_accepts got %0d exp 3", idx); else passed++;
        total++; if (rdy_seen !== 8'b11010101) $display("FAIL b2b_ready got %b exp 11010101", rdy_seen); else passed++;
        total++; if (done_seen !== 8'b00101010) $display("FAIL b2b_done got %b exp 00101010", done_seen); else passed++;
        dbg_sel = 3'd6; #1;
        total++; if (dbg_data !== 16'h0011) $display("FAIL b2b_r6 got %h exp 0011", dbg_data); else passed++;
        dbg_sel = 3'd5; #1;
        total++; if (dbg_data !== 16'h0011) $display("FAIL b2b_r5 got %h exp 0011", dbg_data); else passed++;
        dbg_sel = 3'd3; #1;
        total++; if (dbg_data !== 16'h0022) $display("FAIL b2b_r3 got %h exp 0022", dbg_data); else passed++;
    endtask

    task automatic test_reset_mid;
        int lat;
        logic seen_done = 1'b0;
        run(1'b0, 3'b001, 3'd0, 3'd0, 16'h00FF, lat); @(negedge clk);
        run(1'b0, 3'b001, 3'd1, 3'd0, 16'h0F0F, lat); @(negedge clk);
        in_op = 3'b110; in_rx = 3'd0; in_ry = 3'd1; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        seen_done |= done;
        @(posedge clk); @(negedge clk);
        total++; if (bus !== 16'h0F0F) $display("FAIL xor_t2_bus got %h exp 0f0f", bus); else passed++;
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        seen_done |= done;
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        total++; if (in_ready !== 1'b1) $display("FAIL rst_mid_ready got %b exp 1", in_ready); else passed++;
        repeat (3) begin
            seen_done |= done;
            @(negedge clk);
        end
        total++; if (seen_done !== 1'b0) $display("FAIL rst_mid_done got %b exp 0", seen_done); else passed++;
        dbg_sel = 3'd0; #1;
        total++; if (dbg_data !== 16'h0000) $display("FAIL rst_mid_r0 got %h exp 0000", dbg_data); else passed++;
        total++; if (flags !== 3'b000) $display("FAIL rst_mid_flags got %b exp 000", flags); else passed++;
    endtask

    task automatic test_nregs6;
        int lat;
        int bad = 0;
        for (int i = 0; i < 6; i++) begin
            run(1'b1, 3'b001, 3'(i), 3'd0, 16'h0100 + 16'(i), lat);
            @(negedge clk);
        end
        run(1'b1, 3'b001, 3'd7, 3'd0, 16'hAAAA, lat);
        total++; if (lat !== 1) $display("FAIL n6_mvi_latency got %0d exp 1", lat); else passed++;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            dbg_sel = 3'(i); #1;
            if (dbg6 !== 16'h0100 + 16'(i)) bad++;
        end
        total++; if (bad != 0) $display("FAIL n6_regs_kept got %0d changed exp 0", bad); else passed++;
        dbg_sel = 3'd7; #1;
        total++; if (dbg6 !== 16'h0000) $display("FAIL n6_dbg7 got %h exp 0000", dbg6); else passed++;
        run(1'b1, 3'b000, 3'd2, 3'd7, 16'h0000, lat);
        total++; if (bus6 !== 16'h0000) $display("FAIL n6_oob_read_bus got %h exp 0000", bus6); else passed++;
        @(negedge clk);
        dbg_sel = 3'd2; #1;
        total++; if (dbg6 !== 16'h0000) $display("FAIL n6_mv_from_r7 got %h exp 0000", dbg6); else passed++;
        total++; if (flags6 !== 3'b000) $display("FAIL n6_flags got %b exp 000", flags6); else passed++;
    endtask

    initial begin
        test_reset;
        test_mvi;
        test_add;
        test_cmp_sub;
        test_logic_ops;
        test_back_to_back;
        test_reset_mid;
        test_nregs6;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
